// File: rtl/bus_xfer_sequencer.sv
// bus_xfer_sequencer: sequences one register-to-register bus transfer as
// DRIVE (source strobe), LATCH (source held + destination strobe), DONE pulse.
// Requests are only accepted in IDLE or DONE, giving 3 cycles per transfer
// when req is held high.
// Optional build macro BUS_XFER_CHECK_EN: codes above 23 are rejected with a
// one-cycle done+err pulse. When it is undefined, every 5-bit code is decoded
// and err stays low.
module bus_xfer_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic        req,
  input  logic [4:0]  src_sel,
  input  logic [4:0]  dst_sel,
  output logic [31:0] out_en,
  output logic [31:0] in_en,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned CodeW   = 5;
  localparam int unsigned StrobeW = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StLatch = 2'd2,
    StDone  = 2'd3
  } xferStateT;

  xferStateT          state;
  xferStateT          stateNext;
  logic [CodeW-1:0]   srcCode;
  logic [CodeW-1:0]   dstCode;
  logic [CodeW-1:0]   srcCodeNext;
  logic [CodeW-1:0]   dstCodeNext;
  logic [StrobeW-1:0] outEnNext;
  logic [StrobeW-1:0] inEnNext;
  logic               busyNext;
  logic               doneNext;
  logic               errNext;
  logic               codeBad;

  // Decode a bus code into its one-hot strobe.
  function automatic logic [StrobeW-1:0] oneHot(input logic [CodeW-1:0] code);
    oneHot = StrobeW'(1) << code;
  endfunction

  // Flag request codes that fall outside the populated bus range.
`ifdef BUS_XFER_CHECK_EN
  localparam logic [CodeW-1:0] MaxCode = CodeW'(23);
  assign codeBad = (src_sel > MaxCode) || (dst_sel > MaxCode);
`else
  assign codeBad = 1'b0;
`endif

  // Next state, next captured codes and next registered outputs.
  always_comb begin
    stateNext   = state;
    srcCodeNext = srcCode;
    dstCodeNext = dstCode;
    outEnNext   = '0;
    inEnNext    = '0;
    busyNext    = 1'b0;
    doneNext    = 1'b0;
    errNext     = 1'b0;
    case (state)
      StIdle, StDone: begin
        if (req) begin
          srcCodeNext = src_sel;
          dstCodeNext = dst_sel;
          if (codeBad) begin
            // Rejected request: skip straight to the completion pulse.
            stateNext = StDone;
            doneNext  = 1'b1;
            errNext   = 1'b1;
          end else begin
            stateNext = StDrive;
            outEnNext = oneHot(src_sel);
            busyNext  = 1'b1;
          end
        end else begin
          stateNext = StIdle;
        end
      end
      StDrive: begin
        // Source keeps driving while the destination loads.
        stateNext = StLatch;
        outEnNext = out_en;
        inEnNext  = oneHot(dstCode);
        busyNext  = 1'b1;
      end
      StLatch: begin
        stateNext = StDone;
        doneNext  = 1'b1;
      end
      default: begin
        stateNext = StIdle;
      end
    endcase
  end

  // State, captured codes and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= StIdle;
      srcCode <= '0;
      dstCode <= '0;
      out_en  <= '0;
      in_en   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= stateNext;
      srcCode <= srcCodeNext;
      dstCode <= dstCodeNext;
      out_en  <= outEnNext;
      in_en   <= inEnNext;
      busy    <= busyNext;
      done    <= doneNext;
      err     <= errNext;
    end
  end

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Testbench for bus_xfer_sequencer. The reference model is a per-edge
// schedule of expected outputs: an accepted request books its three output
// cycles ahead of time, clr wipes the booked cycles.
module tb_bus_xfer_sequencer;

  localparam int unsigned MaxCyc = 2048;
`ifdef BUS_XFER_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr;
  logic        req;
  logic [4:0]  srcSel;
  logic [4:0]  dstSel;
  logic [31:0] out_en;
  logic [31:0] in_en;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad = 0;
  int edgeIdx = 0;
  int freeAt = 0;

  logic [31:0] mOut [MaxCyc];
  logic [31:0] mIn  [MaxCyc];
  logic        mBusy[MaxCyc];
  logic        mDone[MaxCyc];
  logic        mErr [MaxCyc];

  bus_xfer_sequencer dut (
    .clk    (clk),
    .clr    (clr),
    .req    (req),
    .src_sel(srcSel),
    .dst_sel(dstSel),
    .out_en (out_en),
    .in_en  (in_en),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Book the expected outputs that result from the inputs seen at edge ix.
  task automatic modelEdge(input int ix);
    if (clr) begin
      for (int k = 0; k < 3; k++) begin
        mOut[ix+k]  = '0;
        mIn[ix+k]   = '0;
        mBusy[ix+k] = 1'b0;
        mDone[ix+k] = 1'b0;
        mErr[ix+k]  = 1'b0;
      end
      freeAt = ix + 1;
    end else if (req && ix >= freeAt) begin
      if (CheckEn && (srcSel > 5'd23 || dstSel > 5'd23)) begin
        mDone[ix] = 1'b1;
        mErr[ix]  = 1'b1;
        freeAt    = ix + 1;
      end else begin
        mOut[ix]    = 32'd1 << srcSel;
        mBusy[ix]   = 1'b1;
        mOut[ix+1]  = 32'd1 << srcSel;
        mIn[ix+1]   = 32'd1 << dstSel;
        mBusy[ix+1] = 1'b1;
        mDone[ix+2] = 1'b1;
        freeAt      = ix + 3;
      end
    end
  endtask

  // Advance one clock; ix is the edge whose result is visible afterwards.
  task automatic tick(output int ix);
    @(posedge clk);
    ix = edgeIdx;
    modelEdge(ix);
    edgeIdx++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int ix;
    for (int j = 0; j < 3; j++) begin
      clr = 1'b1; req = 1'b1; srcSel = 5'd4; dstSel = 5'd4;
      tick(ix);
      total++;
      if ({out_en, in_en, busy, done, err} !== 67'd0) begin
        bad++;
        $display("FAIL reset_zero edge=%0d got=%h exp=0", ix, {out_en, in_en, busy, done, err});
      end
    end
    clr = 1'b0; req = 1'b0;
    tick(ix);
    total++;
    if ({out_en, in_en, busy, done, err} !== {mOut[ix], mIn[ix], mBusy[ix], mDone[ix], mErr[ix]}) begin
      bad++;
      $display("FAIL reset_idle edge=%0d got=%h exp=%h", ix, {out_en, in_en, busy, done, err},
               {mOut[ix], mIn[ix], mBusy[ix], mDone[ix], mErr[ix]});
    end
  endtask

  task automatic test_basic();
    logic [31:0] oo[5];
    logic [31:0] ii[5];
    logic        bb[5];
    logic        dd[5];
    int ix;
    for (int j = 0; j < 5; j++) begin
      clr = 1'b0; req = (j == 0);
      srcSel = (j == 0) ? 5'd2 : 5'd0;
      dstSel = (j == 0) ? 5'd5 : 5'd0;
      tick(ix);
      oo[j] = out_en; ii[j] = in_en; bb[j] = busy; dd[j] = done;
      total++;
      if ({out_en, in_en, busy, done, err} !== {mOut[ix], mIn[ix], mBusy[ix], mDone[ix], mErr[ix]}) begin
        bad++;
        $display("FAIL basic_model edge=%0d got=%h exp=%h", ix, {out_en, in_en, busy, done, err},
                 {mOut[ix], mIn[ix], mBusy[ix], mDone[ix], mErr[ix]});
      end
    end
    total++;
    if (oo[0] !== 32'h4 || oo[1] !== 32'h4 || oo[2] !== 32'h0) begin
      bad++;
      $display("FAIL basic_out_en got=%h,%h,%h exp=4,4,0", oo[0], oo[1], oo[2]);
    end
    total++;
    if (ii[0] !== 32'h0 || ii[1] !== 32'h20 || ii[2] !== 32'h0) begin
      bad++;
      $display("FAIL basic_in_en got=%h,%h,%h exp=0,20,0", ii[0], ii[1], ii[2]);
    end
    total++;
    if ({bb[0], bb[1], bb[2], dd[1], dd[2], dd[3]} !== 6'b110010) begin
      bad++;
      $display("FAIL basic_busy_done got=%b exp=110010", {bb[0], bb[1], bb[2], dd[1], dd[2], dd[3]});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] oo[7];
    logic [31:0] ii[7];
    logic        dd[7];
    int ix;
    for (int j = 0; j < 7; j++) begin
      clr = 1'b0; req = (j <= 3);
      srcSel = (j == 0) ? 5'd0 : 5'd23;
      dstSel = (j == 0) ? 5'd1 : 5'd15;
      tick(ix);
      oo[j] = out_en; ii[j] = in_en; dd[j] = done;
      total++;
      if ({out_en, in_en, busy, done, err} !== {mOut[ix], mIn[ix], mBusy[ix], mDone[ix], mErr[ix]}) begin
        bad++;
        $display("FAIL b2b_model edge=%0d got=%h exp=%h", ix, {out_en, in_en, busy, done, err},
                 {mOut[ix], mIn[ix], mBusy[ix], mDone[ix], mErr[ix]});
      end
    end
    total++;
    if (oo[0] !== 32'h1 || oo[1] !== 32'h1 || ii[1] !== 32'h2 || dd[2] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first got=%h,%h,%h,%b exp=1,1,2,1", oo[0], oo[1], ii[1], dd[2]);
    end
    total++;
    if (oo[3] !== 32'h00800000 || oo[4] !== 32'h00800000 || ii[3] !== 32'h0 ||
        ii[4] !== 32'h00008000 || dd[5] !== 1'b1 || oo[6] !== 32'h0) begin
      bad++;
      $display("FAIL b2b_second got=%h,%h,%h,%h,%b exp=800000,800000,0,8000,1",
               oo[3], oo[4], ii[3], ii[4], dd[5]);
    end
  endtask

  task automatic test_ignore_busy();
    logic [31:0] oo[6];
    logic [31:0] ii[6];
    logic        bb[6];
    int ix;
    for (int j = 0; j < 6; j++) begin
      clr = 1'b0; req = (j <= 2);
      srcSel = (j == 0) ? 5'd2 : 5'd7;
      dstSel = (j == 0) ? 5'd5 : 5'd9;
      tick(ix);
      oo[j] = out_en; ii[j] = in_en; bb[j] = busy;
      total++;
      if ({out_en, in_en, busy, done, err} !== {mOut[ix], mIn[ix], mBusy[ix], mDone[ix], mErr[ix]}) begin
        bad++;
        $display("FAIL ignore_model edge=%0d got=%h exp=%h", ix, {out_en, in_en, busy, done, err},
                 {mOut[ix], mIn[ix], mBusy[ix], mDone[ix], mErr[ix]});
      end
    end
    total++;
    if (oo[0] !== 32'h4 || oo[1] !== 32'h4 || ii[1] !== 32'h20 ||
        oo[3] !== 32'h0 || bb[3] !== 1'b0 || bb[4] !== 1'b0) begin
      bad++;
      $display("FAIL ignore_busy got=%h,%h,%h,%h,%b%b exp=4,4,20,0,00", oo[0], oo[1], ii[1], oo[3], bb[3], bb[4]);
    end
  endtask

  task automatic test_reset_mid();
    logic [66:0] vv[7];
    logic        anyDone;
    int ix;
    anyDone = 1'b0;
    for (int j = 0; j < 7; j++) begin
      clr = (j == 2);
      req = (j == 0) || (j == 3);
      srcSel = (j == 0) ? 5'd4 : 5'd1;
      dstSel = (j == 0) ? 5'd6 : 5'd2;
      tick(ix);
      vv[j] = {out_en, in_en, busy, done, err};
      if (j <= 2 && done) anyDone = 1'b1;
      total++;
      if ({out_en, in_en, busy, done, err} !== {mOut[ix], mIn[ix], mBusy[ix], mDone[ix], mErr[ix]}) begin
        bad++;
        $display("FAIL rstmid_model edge=%0d got=%h exp=%h", ix, {out_en, in_en, busy, done, err},
                 {mOut[ix], mIn[ix], mBusy[ix], mDone[ix], mErr[ix]});
      end
    end
    total++;
    if (vv[2] !== 67'd0 || anyDone !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_abort got=%h done_seen=%b exp=0 done_seen=0", vv[2], anyDone);
    end
    total++;
    if (vv[3][66:35] !== 32'h2 || vv[4][34:3] !== 32'h4 || vv[5][1] !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_restart got=%h,%h,%b exp=2,4,1", vv[3][66:35], vv[4][34:3], vv[5][1]);
    end
  endtask

  task automatic test_invalid();
    logic [31:0] oo[5];
    logic [31:0] ii[5];
    logic        dd[5];
    logic        ee[5];
    int ix;
    for (int j = 0; j < 5; j++) begin
      clr = 1'b0; req = (j == 0);
      srcSel = 5'd26; dstSel = 5'd3;
      tick(ix);
      oo[j] = out_en; ii[j] = in_en; dd[j] = done; ee[j] = err;
      total++;
      if ({out_en, in_en, busy, done, err} !== {mOut[ix], mIn[ix], mBusy[ix], mDone[ix], mErr[ix]}) begin
        bad++;
        $display("FAIL invalid_model edge=%0d got=%h exp=%h", ix, {out_en, in_en, busy, done, err},
                 {mOut[ix], mIn[ix], mBusy[ix], mDone[ix], mErr[ix]});
      end
    end
    total++;
    if (CheckEn) begin
      if (oo[0] !== 32'h0 || ii[0] !== 32'h0 || dd[0] !== 1'b1 || ee[0] !== 1'b1 || ee[1] !== 1'b0) begin
        bad++;
        $display("FAIL invalid_checked got=%h,%h,%b,%b,%b exp=0,0,1,1,0", oo[0], ii[0], dd[0], ee[0], ee[1]);
      end
    end else begin
      if (oo[0] !== 32'h04000000 || oo[1] !== 32'h04000000 || ii[1] !== 32'h8 ||
          dd[2] !== 1'b1 || {ee[0], ee[1], ee[2], ee[3]} !== 4'b0) begin
        bad++;
        $display("FAIL invalid_unchecked got=%h,%h,%h,%b,%b exp=4000000,4000000,8,1,0",
                 oo[0], oo[1], ii[1], dd[2], {ee[0], ee[1], ee[2], ee[3]});
      end
    end
  endtask

  task automatic test_random();
    int ix;
    for (int j = 0; j < 400; j++) begin
      clr    = ($urandom_range(0, 19) == 0);
      req    = ($urandom_range(0, 2) != 0);
      srcSel = 5'($urandom_range(0, 31));
      dstSel = 5'($urandom_range(0, 31));
      tick(ix);
      total++;
      if ({out_en, in_en, busy, done, err} !== {mOut[ix], mIn[ix], mBusy[ix], mDone[ix], mErr[ix]}) begin
        bad++;
        $display("FAIL random_model edge=%0d got=%h exp=%h", ix, {out_en, in_en, busy, done, err},
                 {mOut[ix], mIn[ix], mBusy[ix], mDone[ix], mErr[ix]});
      end
      total++;
      if ($countones(out_en) > 1 || $countones(in_en) > 1 || (in_en != 32'h0 && out_en == 32'h0)) begin
        bad++;
        $display("FAIL random_strobe edge=%0d out_en=%h in_en=%h exp=onehot0 and in_en only with out_en",
                 ix, out_en, in_en);
      end
    end
    clr = 1'b0; req = 1'b0;
    for (int j = 0; j < 4; j++) tick(ix);
  endtask

  initial begin
    for (int i = 0; i < MaxCyc; i++) begin
      mOut[i] = '0; mIn[i] = '0; mBusy[i] = 1'b0; mDone[i] = 1'b0; mErr[i] = 1'b0;
    end
    clr = 1'b1; req = 1'b0; srcSel = 5'd0; dstSel = 5'd0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_invalid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_xfer_sequencer.md
BUS_XFER_SEQUENCER -- requirements
Module: bus_xfer_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: clr  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: req  input  1  transfer request from control unit, level-sampled.
REQ-004 SHALL have port: src_sel  input  5  encoded bus source code (0..23 valid).
REQ-005 SHALL have port: dst_sel  input  5  encoded bus destination code (0..23 valid).
REQ-006 SHALL have port: out_en  output  32  one-hot source drive strobe to bus mux, bit n = code n.
REQ-007 SHALL have port: in_en  output  32  one-hot destination load strobe, bit n = code n.
REQ-008 SHALL have port: busy  output  1  high in DRIVE and LATCH.
REQ-009 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: err  output  1  one-cycle invalid-code pulse; present in all builds.

Function
REQ-011 SHALL implement states IDLE, DRIVE, LATCH, DONE; all outputs registered.
REQ-012 SHALL sample req, src_sel, dst_sel only in IDLE or DONE; req=1 at edge k captures both codes into internal registers; inputs ignored in DRIVE/LATCH.
REQ-013 SHALL in DRIVE (cycle k+1): out_en = one-hot(captured src), in_en = 0, busy = 1.
REQ-014 SHALL in LATCH (cycle k+2): out_en held unchanged, in_en = one-hot(captured dst), busy = 1.
REQ-015 SHALL in DONE (cycle k+3): out_en = 0, in_en = 0, busy = 0, done = 1.
REQ-016 SHALL go DONE -> DRIVE if req=1 at DONE edge (back-to-back, throughput 3 cycles/transfer), else DONE -> IDLE.
REQ-017 SHALL stay in IDLE while req=0, all outputs 0.
REQ-018 SHALL permit src = dst (same one-hot bit in out_en and in_en during LATCH).
REQ-019 SHALL guarantee popcount(out_en) <= 1 and popcount(in_en) <= 1 every cycle.
REQ-020 SHALL never assert in_en in a cycle where out_en is 0.
REQ-021 SHALL decode codes 24..31 to bits 24..31 when BUS_XFER_CHECK_EN is undefined (no checking).

Reset
REQ-022 SHALL on clr=1 at a rising edge: state = IDLE, out_en = 0, in_en = 0, busy = 0, done = 0, err = 0, captured codes = 0.
REQ-023 SHALL give clr priority over req and over any in-progress transfer; aborted transfer produces no done or err.
REQ-024 SHALL accept a new req at the first edge with clr=0.

Configuration
REQ-025 SHALL use macro BUS_XFER_CHECK_EN to compile code checking in or out.
REQ-026 SHALL with BUS_XFER_CHECK_EN defined: accepted req with src_sel > 23 or dst_sel > 23 -> next state DONE directly, done = 1 and err = 1 for that cycle, out_en and in_en remain 0.
REQ-027 SHALL with BUS_XFER_CHECK_EN undefined: err tied to 0, all 32 codes sequenced normally per REQ-013..015.

Verification
REQ-028 SHALL verify basic: src=2, dst=5, req pulse at edge 0 -> out_en=0x00000004 cycles 1-2, in_en=0x00000020 cycle 2 only, done=1 cycle 3, busy=1 cycles 1-2.
REQ-029 SHALL verify back-to-back: req held high, codes (0,1) then (23,15) -> out_en 0x1 cycles 1-2, done cycle 3, out_en 0x00800000 cycles 4-5, in_en 0x00008000 cycle 5, done cycle 6.
REQ-030 SHALL verify ignore-while-busy: req with src=7 during DRIVE/LATCH -> outputs unchanged from first transfer, no extra transfer started.
REQ-031 SHALL verify reset mid-op: clr=1 at LATCH edge -> next cycle all outputs 0, state IDLE, no done pulse.
REQ-032 SHALL verify invalid code: src=26, dst=3 with BUS_XFER_CHECK_EN -> cycle 1 done=1, err=1, out_en=in_en=0; without macro -> out_en=0x04000000 cycles 1-2, in_en=0x00000008 cycle 2, err=0.
